// File: rtl/edge_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_det_pkg
// Description : Shared types and constants for the multi-channel edge
//               detector: the per-channel edge mode encoding and the bit
//               positions of the rise/fall qualifiers inside a mode field.
//               Also provides the edge qualification helper used by every
//               channel.
// Macros      : none (EDGE_DET_FILTER_EN is consumed by edge_det_chan)
// Revision    : 1.0 - initial release
// ============================================================================
package edge_det_pkg;

  // Per-channel edge qualifier. The two bits are independent enables, so
  // BOTH is simply RISE | FALL.
  typedef enum logic [1:0] {
    NONE = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_t;

  localparam int MODE_RISE_BIT = 0;
  localparam int MODE_FALL_BIT = 1;

  // An edge counts towards the pending flag only if the mode enables it.
  function automatic logic qualify_edge(input logic       rise_p,
                                        input logic       fall_p,
                                        input logic [1:0] mode_v);
    return (rise_p & mode_v[MODE_RISE_BIT]) | (fall_p & mode_v[MODE_FALL_BIT]);
  endfunction

endpackage : edge_det_pkg
`default_nettype wire

// File: rtl/edge_det_chan.sv
`default_nettype none
// ============================================================================
// Module      : edge_det_chan
// Description : One edge detector channel. The raw input passes through a
//               flop synchroniser, an optional debounce filter, and an edge
//               stage that produces registered rise/fall pulses. A sticky
//               pending flag records edges that the channel mode qualifies.
// Macros      : EDGE_DET_FILTER_EN - when defined, a debounce counter must
//               see FILTER_CYCLES consecutive mismatching cycles before the
//               filtered level follows the synchronised level. When
//               undefined, the filtered level is the synchronised level.
// Ports       :
//   clk        in  1  clock
//   rst_n      in  1  synchronous active-low reset
//   sig_in     in  1  raw (possibly asynchronous) input
//   mode       in  2  edge qualifier {fall_en, rise_en}
//   clr        in  1  clears pend (a simultaneous qualified edge wins)
//   level_out  out 1  filtered, synchronised level
//   rise       out 1  one-cycle pulse on a filtered 0->1 transition
//   fall       out 1  one-cycle pulse on a filtered 1->0 transition
//   pend       out 1  sticky qualified-edge flag
// Revision    : 1.0 - initial release
// ============================================================================
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level_out,
  output logic       rise,
  output logic       fall,
  output logic       pend
);

  // --------------------------------------------------------------------------
  // Synchroniser: shift the raw input through SYNC_STAGES flops. The last
  // stage is the first point where the level is safe to use.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_lvl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign sync_lvl = sync_ff[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Filtered level
  // --------------------------------------------------------------------------
  logic filt_lvl;

`ifdef EDGE_DET_FILTER_EN
  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
  // The level toggles on the cycle that would bring the count to
  // FILTER_CYCLES, so the counter compares against one less and never
  // needs to hold FILTER_CYCLES itself; it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] filt_cnt;
  logic             filt_ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      filt_ff  <= 1'b0;
    end else if (sync_lvl != filt_ff) begin
      if (filt_cnt == CNT_LAST) begin
        filt_ff  <= ~filt_ff;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      // Any agreeing cycle discards a partial count: glitches shorter than
      // FILTER_CYCLES leave no trace.
      filt_cnt <= '0;
    end
  end

  assign filt_lvl = filt_ff;
`else
  // Without the filter the synchronised level is used as-is. FILTER_CYCLES
  // has no effect in this build; both arms are the same pass-through.
  if (FILTER_CYCLES >= 1) begin : g_nofilt
    assign filt_lvl = sync_lvl;
  end else begin : g_nofilt_degenerate
    assign filt_lvl = sync_lvl;
  end
`endif

  assign level_out = filt_lvl;

  // --------------------------------------------------------------------------
  // Edge stage and pending flag. rise/fall compare the current filtered level
  // with the previous one, so they cannot both be high in one cycle. The
  // pending flag consumes the registered pulses, so it trails them by one
  // cycle, and the mode is sampled in the same cycle as the pulse.
  // --------------------------------------------------------------------------
  logic prev_lvl;
  logic rise_ff;
  logic fall_ff;
  logic pend_ff;
  logic qual_edge;

  assign qual_edge = qualify_edge(rise_ff, fall_ff, mode);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_lvl <= 1'b0;
      rise_ff  <= 1'b0;
      fall_ff  <= 1'b0;
      pend_ff  <= 1'b0;
    end else begin
      prev_lvl <= filt_lvl;
      rise_ff  <= filt_lvl & ~prev_lvl;
      fall_ff  <= ~filt_lvl & prev_lvl;
      // Set has priority over a coincident clear.
      pend_ff  <= qual_edge | (pend_ff & ~clr);
    end
  end

  assign rise = rise_ff;
  assign fall = fall_ff;
  assign pend = pend_ff;

endmodule : edge_det_chan
`default_nettype wire

// File: rtl/edge_detector_mc.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector_mc
// Description : Multi-channel edge detector. CH independent channels, each
//               with synchroniser, optional debounce filter, rise/fall pulse
//               generation and a sticky pending flag qualified by a per-
//               channel edge mode. A registered OR of all pending flags forms
//               the interrupt output.
// Macros      : EDGE_DET_FILTER_EN - compiles the per-channel debounce
//               filter in (see edge_det_chan).
// Ports       :
//   clk        in  1     clock
//   rst_n      in  1     synchronous active-low reset
//   sig_in     in  CH    raw channel inputs
//   mode       in  2*CH  edge qualifiers, channel i uses [2i+1:2i]
//   clr        in  CH    per-channel pending clear
//   level_out  out CH    filtered, synchronised levels
//   rise       out CH    rising edge pulses
//   fall       out CH    falling edge pulses
//   pend       out CH    sticky qualified-edge flags
//   irq        out 1     registered OR of pend
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detector_mc
  import edge_det_pkg::*;
#(
  parameter int CH            = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   sig_in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level_out,
  output logic [CH-1:0]   rise,
  output logic [CH-1:0]   fall,
  output logic [CH-1:0]   pend,
  output logic            irq
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_in    (sig_in[i]),
      .mode      (mode[2*i +: 2]),
      .clr       (clr[i]),
      .level_out (level_out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pend      (pend[i])
    );
  end

  // The interrupt is registered from the pend flops, one cycle behind them.
  logic irq_ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_ff <= 1'b0;
    end else begin
      irq_ff <= |pend;
    end
  end

  assign irq = irq_ff;

endmodule : edge_detector_mc
`default_nettype wire
